// File: rtl/mesa_cmd_rx_pkg.sv
// mesa_pkg: shared constants, parser/receiver state types and one-hot
// decode helpers for the mesa command front-end.
package mesa_pkg;

    localparam logic [7:0] HDR_BYTE = 8'h4D;

    // State codes carried in data byte bits [3:2]
    localparam logic [1:0] ST_L = 2'd0;
    localparam logic [1:0] ST_O = 2'd1;
    localparam logic [1:0] ST_R = 2'd2;

    localparam int N_MESAS = 4;
    localparam int N_STATES = 3;

    typedef enum logic [1:0] {
        WAIT_HDR,
        GET_DATA,
        GET_CHK,
        HOLD
    } parse_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // A data byte is acceptable when the upper nibble is clear and the
    // state code names one of L/O/R.
    function automatic logic data_ok(input logic [7:0] d);
        return (d[7:4] == 4'h0) && (d[3:2] <= ST_R);
    endfunction

    function automatic logic [N_MESAS-1:0] table_onehot(input logic [1:0] idx);
        return N_MESAS'(1) << idx;
    endfunction

    function automatic logic [N_STATES-1:0] state_onehot(input logic [1:0] code);
        return N_STATES'(1) << code;
    endfunction

endpackage

// File: rtl/mesa_cmd_rx_if.sv
// mesa_cmd_rx_if: serial input plus decoded command outputs of the
// mesa command front-end. master = host/driver side, slave = receiver.
interface mesa_cmd_rx_if;
    import mesa_pkg::*;

    logic                rx;
    logic [N_MESAS-1:0]  mes_sel;
    logic [N_STATES-1:0] est_sel;
    logic                cmd_valid;
    logic                cmd_err;
    logic                frame_err;

    modport master (
        output rx,
        input  mes_sel,
        input  est_sel,
        input  cmd_valid,
        input  cmd_err,
        input  frame_err
    );

    modport slave (
        input  rx,
        output mes_sel,
        output est_sel,
        output cmd_valid,
        output cmd_err,
        output frame_err
    );

endinterface

// File: rtl/mesa_cmd_rx_uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with 2-flop input synchronizer,
// mid-bit sampling, start-bit glitch rejection and stop-bit checking.
module uart_rx_8n1
    import mesa_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    rx_state_t        state_reg;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic             frame_err_reg;
    logic             rx_s;

    assign rx_s       = sync_reg[1];
    assign byte_valid = byte_valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = frame_err_reg;

    // Synchronize rx and walk through start/data/stop sampling points
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg       <= 2'b11;
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], rx};
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                // Idle is only reached with the line high, so low here is a falling edge
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end
                // Re-check the start bit at half a bit; a high line means a glitch
                RX_START: begin
                    if (cnt_reg == CNT_W'(HALF - 1)) begin
                        cnt_reg <= '0;
                        if (!rx_s) begin
                            state_reg   <= RX_DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            state_reg <= RX_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == CNT_W'(DIV - 1)) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == CNT_W'(DIV - 1)) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            byte_valid_reg <= 1'b1;
                            state_reg      <= RX_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                // After a broken stop bit, re-arm only once the line is idle again
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_reg <= RX_IDLE;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mesa_cmd_rx.sv
// mesa_cmd_rx: UART command front-end. Validates header/data frames and
// holds one-hot table/state selects for HOLD_CYCLES clocks.
// Optional checksum byte compiled in with `define MESA_CMD_CHK_EN.
module mesa_cmd_rx
    import mesa_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 9600,
    parameter int HOLD_CYCLES  = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    mesa_cmd_rx_if.slave  bus
);

    localparam int DIV       = CLK_HZ / BAUD;
    localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
    localparam int TO_W      = $clog2(TO_CYCLES);
    localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);

    logic       byte_valid;
    logic [7:0] byte_data;

    parse_state_t        state_reg;
    logic [TO_W-1:0]     timer_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [N_MESAS-1:0]  mes_sel_reg;
    logic [N_STATES-1:0] est_sel_reg;
    logic                cmd_valid_reg;
    logic                cmd_err_reg;
`ifdef MESA_CMD_CHK_EN
    logic [7:0]          data_reg;
`endif

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (bus.rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (bus.frame_err)
    );

    assign bus.mes_sel   = mes_sel_reg;
    assign bus.est_sel   = est_sel_reg;
    assign bus.cmd_valid = cmd_valid_reg;
    assign bus.cmd_err   = cmd_err_reg;

    // Frame parser with inter-byte timeout and fixed-length output hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= WAIT_HDR;
            timer_reg     <= '0;
            hold_cnt_reg  <= '0;
            mes_sel_reg   <= '0;
            est_sel_reg   <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
`ifdef MESA_CMD_CHK_EN
            data_reg      <= '0;
`endif
        end else begin
            cmd_err_reg <= 1'b0;
            case (state_reg)
                // Non-header bytes are ignored without complaint
                WAIT_HDR: begin
                    if (byte_valid && (byte_data == HDR_BYTE)) begin
                        state_reg <= GET_DATA;
                        timer_reg <= '0;
                    end
                end
                // Timeout is checked first so it wins over a same-cycle byte
                GET_DATA: begin
                    if (timer_reg == TO_W'(TO_CYCLES - 1)) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= WAIT_HDR;
                    end else if (byte_valid) begin
                        if (!data_ok(byte_data)) begin
                            cmd_err_reg <= 1'b1;
                            state_reg   <= WAIT_HDR;
                        end else begin
`ifdef MESA_CMD_CHK_EN
                            data_reg  <= byte_data;
                            timer_reg <= '0;
                            state_reg <= GET_CHK;
`else
                            mes_sel_reg   <= table_onehot(byte_data[1:0]);
                            est_sel_reg   <= state_onehot(byte_data[3:2]);
                            cmd_valid_reg <= 1'b1;
                            hold_cnt_reg  <= '0;
                            state_reg     <= HOLD;
`endif
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                // Checksum byte must equal header XOR data
                GET_CHK: begin
`ifdef MESA_CMD_CHK_EN
                    if (timer_reg == TO_W'(TO_CYCLES - 1)) begin
                        cmd_err_reg <= 1'b1;
                        state_reg   <= WAIT_HDR;
                    end else if (byte_valid) begin
                        if (byte_data == (HDR_BYTE ^ data_reg)) begin
                            mes_sel_reg   <= table_onehot(data_reg[1:0]);
                            est_sel_reg   <= state_onehot(data_reg[3:2]);
                            cmd_valid_reg <= 1'b1;
                            hold_cnt_reg  <= '0;
                            state_reg     <= HOLD;
                        end else begin
                            cmd_err_reg <= 1'b1;
                            state_reg   <= WAIT_HDR;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
`else
                    state_reg <= WAIT_HDR;
`endif
                end
                // Selects stay up for HOLD_CYCLES clocks; stray bytes are flagged only
                HOLD: begin
                    if (byte_valid) begin
                        cmd_err_reg <= 1'b1;
                    end
                    if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                        mes_sel_reg   <= '0;
                        est_sel_reg   <= '0;
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= WAIT_HDR;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= WAIT_HDR;
            endcase
        end
    end

endmodule
